// File: rtl/frame_diff_pkg.sv
// Shared types and default sizing for the frame-analysis blocks.
//   bbox_state_t : tracker FSM states
//   DEF_*        : default parameter values for bbox_tracker / bbox_xy_cnt
package frame_diff_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } bbox_state_t;

  localparam int DEF_H_ACT   = 1280;
  localparam int DEF_V_ACT   = 720;
  localparam int DEF_CW      = 11;
  localparam int DEF_MIN_PIX = 16;
  localparam int DEF_MAX_BOX = 500;
  localparam int DEF_PW      = 21;

endpackage

// File: rtl/bbox_xy_cnt.sv
// Pixel coordinate counter driven purely by the valid strobe.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous restart to (0,0); wins over en
//   en       : advance one pixel
//   x, y     : coordinate of the pixel currently presented
//   last     : current coordinate is (H_ACT-1, V_ACT-1)
module bbox_xy_cnt
  import frame_diff_pkg::*;
#(
  parameter int H_ACT = DEF_H_ACT,
  parameter int V_ACT = DEF_V_ACT,
  parameter int CW    = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  localparam logic [CW-1:0] X_LAST = CW'(H_ACT - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_ACT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_LAST) begin
        x <= '0;
        // y wraps too so a stray pixel after the frame cannot run off the end
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/bbox_tracker.sv
// Bounding-box tracker for a binary foreground stream.
//   clk, rst         : clock, async active-high reset
//   pre_img_vsync    : frame sync, rising edge starts/restarts a frame
//   pre_img_valid    : active-pixel strobe
//   pre_img_data     : 1 = foreground
//   box_valid        : latched result reached MIN_PIX
//   top/bottom/left/right_edge : latched box (bottom/right clamped to MAX_BOX)
//   pix_cnt          : latched foreground count
//   frame_done       : one-cycle pulse with each new latched result
//   frame_err        : one-cycle pulse when a frame is aborted by vsync
module bbox_tracker
  import frame_diff_pkg::*;
#(
  parameter int H_ACT   = DEF_H_ACT,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int CW      = DEF_CW,
  parameter int MIN_PIX = DEF_MIN_PIX,
  parameter int MAX_BOX = DEF_MAX_BOX,
  parameter int PW      = DEF_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pre_img_vsync,
  input  logic          pre_img_valid,
  input  logic          pre_img_data,
  output logic          box_valid,
  output logic [CW-1:0] top_edge,
  output logic [CW-1:0] bottom_edge,
  output logic [CW-1:0] left_edge,
  output logic [CW-1:0] right_edge,
  output logic [PW-1:0] pix_cnt,
  output logic          frame_done,
  output logic          frame_err
);

  localparam logic [CW:0] BOX_M1 = (CW+1)'(MAX_BOX - 1);

  bbox_state_t state, state_nxt;
  logic          vs_d, vs_pos;
  logic          px_en, fg_hit, last_px, at_last;
  logic [CW-1:0] x, y;
  logic [CW-1:0] min_x, max_x, min_y, max_y;
  logic [CW-1:0] min_x_n, max_x_n, min_y_n, max_y_n;
  logic [PW-1:0] cnt, cnt_n;
  logic [CW:0]   bot_lim, rgt_lim;
  logic [CW-1:0] bot_c, rgt_c;
  logic          box_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vs_d <= 1'b0;
    else     vs_d <= pre_img_vsync;
  end

  assign vs_pos  = pre_img_vsync & ~vs_d;
  assign px_en   = (state == ACTIVE) & pre_img_valid;
  // vsync always wins over the pixel presented in the same cycle
  assign fg_hit  = px_en & pre_img_data & ~vs_pos;
  assign last_px = px_en & at_last & ~vs_pos;

  bbox_xy_cnt #(.H_ACT(H_ACT), .V_ACT(V_ACT), .CW(CW)) u_xy (
    .clk  (clk),
    .rst  (rst),
    .clr  (vs_pos),
    .en   (px_en),
    .x    (x),
    .y    (y),
    .last (at_last)
  );

  // accumulator values including the pixel sampled this cycle; the result
  // latch reads these so the final pixel is part of the reported box
  always_comb begin
    min_x_n = min_x;
    max_x_n = max_x;
    min_y_n = min_y;
    max_y_n = max_y;
    cnt_n   = cnt;
    if (fg_hit) begin
      if (x < min_x) min_x_n = x;
      if (x > max_x) max_x_n = x;
      if (y < min_y) min_y_n = y;
      if (y > max_y) max_y_n = y;
      if (cnt != '1) cnt_n = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_x <= '0;
      max_x <= '0;
      min_y <= '0;
      max_y <= '0;
      cnt   <= '0;
    end else if (vs_pos) begin
      min_x <= '1;
      max_x <= '0;
      min_y <= '1;
      max_y <= '0;
      cnt   <= '0;
    end else begin
      min_x <= min_x_n;
      max_x <= max_x_n;
      min_y <= min_y_n;
      max_y <= max_y_n;
      cnt   <= cnt_n;
    end
  end

  // one extra bit keeps min+MAX_BOX-1 from wrapping below max
  assign bot_lim = {1'b0, min_y_n} + BOX_M1;
  assign rgt_lim = {1'b0, min_x_n} + BOX_M1;
  assign bot_c   = ({1'b0, max_y_n} < bot_lim) ? max_y_n : bot_lim[CW-1:0];
  assign rgt_c   = ({1'b0, max_x_n} < rgt_lim) ? max_x_n : rgt_lim[CW-1:0];
  assign box_ok  = (cnt_n >= PW'(MIN_PIX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (vs_pos) state_nxt = ACTIVE;
      ACTIVE:  if (last_px) state_nxt = DONE;
      DONE:    state_nxt = vs_pos ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // results are loaded on the edge that enters DONE, so they and frame_done
  // are visible together for the single DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_valid   <= 1'b0;
      top_edge    <= '0;
      bottom_edge <= '0;
      left_edge   <= '0;
      right_edge  <= '0;
      pix_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= (state == ACTIVE) & vs_pos;
      if (last_px) begin
        frame_done  <= 1'b1;
        box_valid   <= box_ok;
        pix_cnt     <= cnt_n;
        top_edge    <= box_ok ? min_y_n : '0;
        bottom_edge <= box_ok ? bot_c   : '0;
        left_edge   <= box_ok ? min_x_n : '0;
        right_edge  <= box_ok ? rgt_c   : '0;
      end
    end
  end

endmodule

// File: tb/tb_bbox_tracker.sv
module tb_bbox_tracker;

  localparam int H = 16, V = 8, MINP = 2, MAXB = 6, CW = 11, PW = 21;
  localparam int NPIX = H * V;

  typedef struct {
    int bv; int top; int bot; int lft; int rgt; int cnt;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic vs = 1'b0, vld = 1'b0, dat = 1'b0;
  logic box_valid, frame_done, frame_err;
  logic [CW-1:0] top_edge, bottom_edge, left_edge, right_edge;
  logic [PW-1:0] pix_cnt;

  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
  exp_t sb[$];
  exp_t held;

  always #5 clk = ~clk;

  bbox_tracker #(.H_ACT(H), .V_ACT(V), .CW(CW), .MIN_PIX(MINP), .MAX_BOX(MAXB), .PW(PW)) dut (
    .clk(clk), .rst(rst), .pre_img_vsync(vs), .pre_img_valid(vld), .pre_img_data(dat),
    .box_valid(box_valid), .top_edge(top_edge), .bottom_edge(bottom_edge),
    .left_edge(left_edge), .right_edge(right_edge), .pix_cnt(pix_cnt),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input exp_t e);
    chk({tag, ".box_valid"}, 32'(box_valid), e.bv);
    chk({tag, ".top"},       32'(top_edge), e.top);
    chk({tag, ".bottom"},    32'(bottom_edge), e.bot);
    chk({tag, ".left"},      32'(left_edge), e.lft);
    chk({tag, ".right"},     32'(right_edge), e.rgt);
    chk({tag, ".pix_cnt"},   32'(pix_cnt), e.cnt);
  endtask

  // reference: scan the image, then apply clamp / threshold rules
  function automatic exp_t model(input logic [NPIX-1:0] img);
    exp_t e;
    int mnx = 1 << 20, mxx = -1, mny = 1 << 20, mxy = -1, c = 0;
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        if (img[yy*H + xx]) begin
          c++;
          if (xx < mnx) mnx = xx;
          if (xx > mxx) mxx = xx;
          if (yy < mny) mny = yy;
          if (yy > mxy) mxy = yy;
        end
    e.cnt = c;
    if (c >= MINP) begin
      e.bv = 1; e.top = mny; e.lft = mnx;
      e.bot = (mxy < mny + MAXB - 1) ? mxy : mny + MAXB - 1;
      e.rgt = (mxx < mnx + MAXB - 1) ? mxx : mnx + MAXB - 1;
    end else begin
      e.bv = 0; e.top = 0; e.bot = 0; e.lft = 0; e.rgt = 0;
    end
    return e;
  endfunction

  function automatic logic [NPIX-1:0] rect(input int x0, input int x1, input int y0, input int y1);
    logic [NPIX-1:0] img = '0;
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) img[yy*H + xx] = 1'b1;
    return img;
  endfunction

  // result monitor: every frame_done must match the oldest queued expectation
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (frame_done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_frame_done", 32'(frame_done), 0);
      end else begin
        e = sb.pop_front();
        chk_outs("result", e);
      end
    end
  end

  task automatic send_vs();
    vs = 1'b1; @(posedge clk); #1;
    vs = 1'b0; @(posedge clk); #1;
  endtask

  task automatic stream(input logic [NPIX-1:0] img, input int n, input bit vs_on_last);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        vld = 1'b0; dat = 1'b1; @(posedge clk); #1;
      end
      vld = 1'b1; dat = img[i];
      if (vs_on_last && i == n - 1) vs = 1'b1;
      @(posedge clk); #1;
    end
    vld = 1'b0; dat = 1'b0; vs = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [NPIX-1:0] img);
    send_vs();
    sb.push_back(model(img));
    held = model(img);
    stream(img, NPIX, 1'b0);
    @(negedge clk); chk({tag, ".done_pulse"}, 32'(frame_done), 1);
    @(negedge clk); chk({tag, ".done_clear"}, 32'(frame_done), 0);
  endtask

  initial begin
    logic [NPIX-1:0] img_a, img_clamp, img_one, img_ab, img_clean, img_full;
    int snap;
    img_a = rect(3, 5, 2, 4);
    img_clamp = '0; img_clamp[0] = 1'b1; img_clamp[7*H + 15] = 1'b1;
    img_one = '0; img_one[3*H + 7] = 1'b1;
    img_ab = rect(10, 12, 0, 1);
    img_clean = rect(1, 2, 5, 6);
    img_full = '1;

    // reset state
    #12;
    chk_outs("reset", '{0, 0, 0, 0, 0, 0});
    chk("reset.frame_done", 32'(frame_done), 0);
    chk("reset.frame_err", 32'(frame_err), 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // pixels before any vsync are ignored
    stream(img_full, 20, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("idle.no_done", 32'(done_cnt), 0);

    run_frame("single_box", img_a);
    run_frame("clamp", img_clamp);
    run_frame("under_thresh", img_one);

    // early abort after 40 pixels, then a clean frame
    send_vs();
    stream(img_ab, 40, 1'b0);
    vs = 1'b1; @(posedge clk); #1;
    chk("abort.err_pulse", 32'(frame_err), 1);
    chk_outs("abort.hold", held);
    vs = 1'b0; @(posedge clk); #1;
    chk("abort.err_clear", 32'(frame_err), 0);
    sb.push_back(model(img_clean));
    held = model(img_clean);
    stream(img_clean, NPIX, 1'b0);
    @(negedge clk); chk("abort.clean_done", 32'(frame_done), 1);
    chk("abort.err_once", 32'(err_cnt), 1);

    // reset in the middle of a frame
    send_vs();
    stream(img_full, 50, 1'b0);
    rst = 1'b1; #2;
    chk_outs("midrst", '{0, 0, 0, 0, 0, 0});
    @(posedge clk); #1; rst = 1'b0;
    snap = done_cnt;
    stream(img_full, NPIX, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("midrst.no_done", 32'(done_cnt), 32'(snap));

    // vsync coincident with the final pixel
    run_frame("pre_collide", img_a);
    send_vs();
    stream(img_clamp, NPIX, 1'b1);
    chk("collide.err", 32'(frame_err), 1);
    chk("collide.done", 32'(frame_done), 0);
    chk_outs("collide.hold", held);
    @(negedge clk); chk("collide.done_late", 32'(frame_done), 0);

    // the restarted frame runs from (0,0) without a new vsync
    sb.push_back(model(img_one));
    stream(img_one, NPIX, 1'b0);
    @(negedge clk); chk("recover.done", 32'(frame_done), 1);

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", 32'(sb.size()), 0);
    chk("err_total", 32'(err_cnt), 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/bbox_tracker.md
BBOX_TRACKER -- requirements
Module: bbox_tracker

Interface
REQ-001 Parameters: H_ACT (default 1280), active pixels per line; V_ACT (default 720), active lines per frame; CW (default 11), coordinate width; MIN_PIX (default 16), minimum foreground count for a valid box; MAX_BOX (default 500), maximum box extent in pixels/lines; PW (default 21), pixel-count width.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: the single clock; all logic is sampled on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- pre_img_vsync, in, 1: frame sync; its rising edge starts a frame.
- pre_img_valid, in, 1: active-pixel strobe.
- pre_img_data, in, 1: binary pixel; 1 = foreground.
- box_valid, out, 1: the latched result meets MIN_PIX.
- top_edge, out, CW: latched minimum y.
- bottom_edge, out, CW: latched maximum y, clamped.
- left_edge, out, CW: latched minimum x.
- right_edge, out, CW: latched maximum x, clamped.
- pix_cnt, out, PW: latched foreground pixel count.
- frame_done, out, 1: one-cycle pulse when a result is latched.
- frame_err, out, 1: one-cycle pulse when a frame is aborted.

Function
REQ-003 The block shall register pre_img_vsync once and detect its rising edge as vs_pos.
REQ-004 Coordinates x and y shall be counted from pre_img_valid only, not from sync timing.
- x increments on each valid pixel and wraps to 0 after H_ACT-1.
- y increments on each x wrap.
- Both reset to 0 on vs_pos.
REQ-005 The FSM shall have three states: IDLE, ACTIVE, and DONE.
- IDLE to ACTIVE on vs_pos.
- ACTIVE to DONE on the valid pixel at x=H_ACT-1, y=V_ACT-1.
- DONE to IDLE after one cycle.
REQ-006 While in IDLE, valid pixels shall be ignored and leave x, y, and all accumulators unchanged.
REQ-007 On vs_pos the accumulators shall initialise in every state:
- min_y and min_x to all-ones;
- max_y and max_x to 0;
- count to 0.
REQ-008 On each foreground pixel in ACTIVE:
- min_x = min(min_x, x), max_x = max(max_x, x);
- min_y = min(min_y, y), max_y = max(max_y, y);
- count increments and saturates at 2^PW-1.
REQ-009 The pixel at x=0, y=0 shall be tracked like any other pixel; 0 is never used as an "unset" sentinel.
REQ-010 In DONE, the output registers shall latch the accumulators and frame_done shall pulse in the same cycle, one clock after the final pixel.
REQ-011 Latched values in DONE:
- bottom_edge = min(max_y, min_y+MAX_BOX-1);
- right_edge = min(max_x, min_x+MAX_BOX-1);
- the additions shall be computed at CW+1 bits so they cannot overflow.
REQ-012 In DONE, if count < MIN_PIX: box_valid = 0, all edge outputs = 0, and pix_cnt = count.
REQ-013 A vs_pos while in ACTIVE shall abort the frame and restart it:
- frame_err pulses for one cycle;
- the outputs keep their previous values;
- the FSM stays in ACTIVE with the accumulators re-initialised.
REQ-014 If vs_pos and the final pixel occur in the same cycle, vs_pos wins and REQ-013 applies.
REQ-015 Outputs shall change only in DONE; between frames they hold their last values.

Reset
REQ-016 On rst, all outputs and the FSM shall clear asynchronously: outputs to 0, FSM to IDLE, x/y/accumulators to 0, vsync delay register to 0.
REQ-017 An rst asserted mid-frame shall discard the partial frame; the next frame starts only after a fresh vs_pos.

Structure
REQ-018 The FSM state enum and default-width constants shall live in the shared package frame_diff_pkg.
REQ-019 One sub-module, bbox_xy_cnt, shall contain the x/y counter with H_ACT and V_ACT parameters and a last-pixel flag output.

Verification
REQ-020 Benches shall use H_ACT=16, V_ACT=8, MIN_PIX=2, MAX_BOX=6 and cover these scenarios:
- Single-box frame: foreground block x 3..5, y 2..4 -> frame_done 1 cycle after the last pixel; top=2, bottom=4, left=3, right=5, pix_cnt=9, box_valid=1.
- Clamping: foreground at (0,0) and (15,7) -> top=0, left=0, bottom=5, right=5, box_valid=1.
- Under threshold: one foreground pixel at (7,3) -> box_valid=0, edges=0, pix_cnt=1.
- Early abort: vs_pos after 40 valid pixels, then a full clean frame -> frame_err pulses once; outputs hold until the clean frame's frame_done, which carries only the second frame's box.
- Reset mid-frame: rst at pixel 50 -> all outputs 0; pixels before the next vs_pos do not produce frame_done.
- Same-cycle collision: vs_pos coincident with the last pixel -> frame_err=1, frame_done=0, outputs unchanged.
